// File: rtl/alu_iterative_if.sv
// Request/result bundle for alu_iterative: operands and opcode in, registered result and flags out.
// Handshake: a request is taken on a rising clock edge where in_valid && in_ready; the requester
// holds in_valid and its operands stable until that edge. out_valid is a one-cycle pulse marking
// that data_result and all flags were updated; they then hold until the next completion.
interface alu_iterative_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [4:0]       ctrl_ALUopcode;
    logic [SHW-1:0]   ctrl_shiftamt;
    logic             out_valid;
    logic [WIDTH-1:0] data_result;
    logic             isNotEqual;
    logic             isLessThan;
    logic             overflow;
    logic             data_exception;

    modport master (
        output in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
        input  in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow, data_exception
    );

    modport slave (
        input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
        output in_ready, out_valid, data_result, isNotEqual, isLessThan, overflow, data_exception
    );
endinterface

// File: rtl/alu_iterative.sv
// Handshaked ALU: single-cycle add/sub/and/or/sll/sra, and iterative signed mul/div that
// retire one bit per cycle. All results and flags are registered and hold until the next completion.
module alu_iterative #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic           clock,
    input  logic           reset,
    alu_iterative_if.slave bus,
    output logic [1:0]     dbg_state
);
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SLL = 5'b00100;
    localparam logic [4:0] OP_SRA = 5'b00101;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t state_q, state_d;
    logic   in_ready, out_valid, accept, is_iter;

    logic [WIDTH-1:0] a, b, sum, diff, abs_a, abs_b;
    logic [4:0]       op;
    logic             add_ovf, sub_ovf, lt_now, ne_now;
    logic [WIDTH-1:0] single_res;
    logic             single_ovf;

    // Iteration state; mplier_q carries the multiplier for mul, dividend/quotient for div.
    logic                 op_div_q, neg_q, bzero_q, minneg_q, ne_p, lt_p;
    logic [SHW-1:0]       cnt_q;
    logic [2*WIDTH-1:0]   prod_q, mcand_q, prod_d, mul_full;
    logic [WIDTH:0]       mul_hi;
    logic [WIDTH-1:0]     mplier_q, rem_q, quo_d, rem_d, div_res;
    logic [WIDTH:0]       rem_sh, rem_sub;
    logic                 rem_ok, mul_ovf;

    logic [WIDTH-1:0] result_q;
    logic             ovf_q, exc_q, ne_q, lt_q;

    assign a   = bus.data_operandA;
    assign b   = bus.data_operandB;
    assign op  = bus.ctrl_ALUopcode;

    assign accept  = bus.in_valid && in_ready;
    assign is_iter = (op == OP_MUL) || (op == OP_DIV);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = is_iter ? S_BUSY : S_DONE;
                else        state_d = S_IDLE;
            end
            S_BUSY:  if (cnt_q == '0) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != S_BUSY);
        out_valid = (state_q == S_DONE);
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign dbg_state     = state_q;

    // Comparison flags come from A-B for every opcode; the xor keeps isLessThan right at the extremes.
    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign lt_now  = diff[WIDTH-1] ^ sub_ovf;
    assign ne_now  = (a != b);
    assign abs_a   = a[WIDTH-1] ? -a : a;
    assign abs_b   = b[WIDTH-1] ? -b : b;

    always_comb begin
        single_res = '0;
        single_ovf = 1'b0;
        case (op)
            OP_ADD: begin single_res = sum;  single_ovf = add_ovf; end
            OP_SUB: begin single_res = diff; single_ovf = sub_ovf; end
            OP_AND: single_res = a & b;
            OP_OR:  single_res = a | b;
            OP_SLL: single_res = a << bus.ctrl_shiftamt;
            OP_SRA: single_res = $signed(a) >>> bus.ctrl_shiftamt;
            default: ;
        endcase
    end

    // One shift-add step (mul) and one restoring-subtract step (div) per cycle.
    assign prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_full = neg_q ? -prod_d : prod_d;
    assign mul_hi   = mul_full[2*WIDTH-1:WIDTH-1];
    assign mul_ovf  = !((&mul_hi) || !(|mul_hi));

    assign rem_sh  = {rem_q, mplier_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
    assign rem_ok  = !rem_sub[WIDTH];
    assign quo_d   = {mplier_q[WIDTH-2:0], rem_ok};
    assign rem_d   = rem_ok ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_res = bzero_q ? '0 : (neg_q ? -quo_d : quo_d);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_div_q <= 1'b0;
            neg_q    <= 1'b0;
            bzero_q  <= 1'b0;
            minneg_q <= 1'b0;
            ne_p     <= 1'b0;
            lt_p     <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rem_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            exc_q    <= 1'b0;
            ne_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else if (accept) begin
            if (is_iter) begin
                op_div_q <= (op == OP_DIV);
                neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                bzero_q  <= (b == '0);
                minneg_q <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                ne_p     <= ne_now;
                lt_p     <= lt_now;
                cnt_q    <= SHW'(WIDTH - 1);
                prod_q   <= '0;
                rem_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, abs_b};
                mplier_q <= abs_a;
            end else begin
                result_q <= single_res;
                ovf_q    <= single_ovf;
                exc_q    <= 1'b0;
                ne_q     <= ne_now;
                lt_q     <= lt_now;
            end
        end else if (state_q == S_BUSY) begin
            if (op_div_q) begin
                mplier_q <= quo_d;
                rem_q    <= rem_d;
            end else begin
                prod_q   <= prod_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else begin
                result_q <= op_div_q ? div_res : mul_full[WIDTH-1:0];
                ovf_q    <= op_div_q ? (minneg_q && !bzero_q) : mul_ovf;
                exc_q    <= op_div_q && bzero_q;
                ne_q     <= ne_p;
                lt_q     <= lt_p;
            end
        end
    end

    assign bus.data_result    = result_q;
    assign bus.overflow       = ovf_q;
    assign bus.data_exception = exc_q;
    assign bus.isNotEqual     = ne_q;
    assign bus.isLessThan     = lt_q;
endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: a 32-bit instance for the main scenarios and an 8-bit
// instance for the narrow multiply.
module tb_alu_iterative;
    logic clk;
    logic rst;
    logic [1:0] dbg_state32;
    logic [1:0] dbg_state8;
    int total;
    int bad;
    logic [31:0] exp_q[$];

    alu_iterative_if #(.WIDTH(32), .SHW(5)) bus32 ();
    alu_iterative_if #(.WIDTH(8),  .SHW(3)) bus8 ();

    alu_iterative #(.WIDTH(32), .SHW(5)) dut32 (
        .clock(clk), .reset(rst), .bus(bus32.slave), .dbg_state(dbg_state32)
    );
    alu_iterative #(.WIDTH(8), .SHW(3)) dut8 (
        .clock(clk), .reset(rst), .bus(bus8.slave), .dbg_state(dbg_state8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic drive32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh);
        @(negedge clk);
        bus32.ctrl_ALUopcode = op;
        bus32.data_operandA  = a;
        bus32.data_operandB  = b;
        bus32.ctrl_shiftamt  = sh;
        bus32.in_valid       = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
    endtask

    // lat = edges after the accept edge until out_valid is seen; busy = sampled cycles with in_ready low
    task automatic wait_done32(output int lat, output int busy);
        lat  = 0;
        busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus32.out_valid) break;
            if (!bus32.in_ready) busy++;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus32.data_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus32.data_result); end
        total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus32.out_valid); end
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus32.in_ready); end
        total++;
        if ({bus32.overflow, bus32.data_exception, bus32.isNotEqual, bus32.isLessThan} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b%b%b%b exp=0000", bus32.overflow, bus32.data_exception,
                     bus32.isNotEqual, bus32.isLessThan);
        end
        total++; if (dbg_state32 !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state32); end
        total++; if (bus8.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready8 got=%b exp=1", bus8.in_ready); end
    endtask

    task automatic test_single;
        logic [4:0]  t_op [8] = '{5'b00000, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b00001, 5'b00000};
        logic [31:0] t_a  [8] = '{32'h7FFFFFFF, 32'h0000F0F0, 32'h0000F0F0, 32'h1, 32'h80000000, 32'h3, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] t_b  [8] = '{32'h1, 32'h0000FF00, 32'h0000FF00, 32'h1, 32'h0, 32'h9, 32'h1, 32'hFFFFFFFF};
        logic [4:0]  t_sh [8] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0};
        logic [31:0] t_res[8] = '{32'h80000000, 32'h0000F000, 32'h0000FFF0, 32'h10, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF, 32'hFFFFFFFE};
        logic        t_ovf[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        t_lt [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        t_ne [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int lat, busy;
        logic [31:0] expv;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(t_res[i]);
            drive32(t_op[i], t_a[i], t_b[i], t_sh[i]);
            wait_done32(lat, busy);
            expv = exp_q.pop_front();
            total++; if (lat != 0) begin bad++; $display("FAIL single_latency[%0d] got=%0d exp=0", i, lat); end
            total++; if (bus32.data_result !== expv) begin bad++; $display("FAIL single_result[%0d] got=%h exp=%h", i, bus32.data_result, expv); end
            total++; if (bus32.overflow !== t_ovf[i]) begin bad++; $display("FAIL single_overflow[%0d] got=%b exp=%b", i, bus32.overflow, t_ovf[i]); end
            total++; if (bus32.isLessThan !== t_lt[i]) begin bad++; $display("FAIL single_lt[%0d] got=%b exp=%b", i, bus32.isLessThan, t_lt[i]); end
            total++; if (bus32.isNotEqual !== t_ne[i]) begin bad++; $display("FAIL single_ne[%0d] got=%b exp=%b", i, bus32.isNotEqual, t_ne[i]); end
            total++; if (bus32.data_exception !== 1'b0) begin bad++; $display("FAIL single_exc[%0d] got=%b exp=0", i, bus32.data_exception); end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0 got=%b exp=1", bus32.in_ready); end
        bus32.ctrl_ALUopcode = 5'b00001;
        bus32.data_operandA  = 32'd5;
        bus32.data_operandB  = 32'd5;
        bus32.in_valid       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (bus32.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid1 got=%b exp=1", bus32.out_valid); end
        total++; if (bus32.data_result !== 32'h0) begin bad++; $display("FAIL b2b_result1 got=%h exp=0", bus32.data_result); end
        total++; if (bus32.isNotEqual !== 1'b0) begin bad++; $display("FAIL b2b_ne1 got=%b exp=0", bus32.isNotEqual); end
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b exp=1", bus32.in_ready); end
        bus32.data_operandA = 32'hFFFFFFFD;
        bus32.data_operandB = 32'd2;
        @(posedge clk);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        total++; if (bus32.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid2 got=%b exp=1", bus32.out_valid); end
        total++; if (bus32.data_result !== 32'hFFFFFFFB) begin bad++; $display("FAIL b2b_result2 got=%h exp=fffffffb", bus32.data_result); end
        total++; if (bus32.isLessThan !== 1'b1) begin bad++; $display("FAIL b2b_lt2 got=%b exp=1", bus32.isLessThan); end
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready2 got=%b exp=1", bus32.in_ready); end
        @(negedge clk);
        total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse_end got=%b exp=0", bus32.out_valid); end
    endtask

    task automatic test_mul;
        int lat, busy;
        drive32(5'b00110, 32'hFFFFFFF9, 32'd6, 5'd0);
        // operands change after the accept edge and must not disturb the result
        bus32.data_operandA = $urandom;
        bus32.data_operandB = $urandom_range(1, 1000);
        wait_done32(lat, busy);
        total++; if (lat != 32) begin bad++; $display("FAIL mul_latency got=%0d exp=32", lat); end
        total++; if (busy != 32) begin bad++; $display("FAIL mul_busy got=%0d exp=32", busy); end
        total++; if (bus32.data_result !== 32'hFFFFFFD6) begin bad++; $display("FAIL mul_result got=%h exp=ffffffd6", bus32.data_result); end
        total++; if (bus32.overflow !== 1'b0) begin bad++; $display("FAIL mul_overflow got=%b exp=0", bus32.overflow); end
        total++; if (bus32.isLessThan !== 1'b1) begin bad++; $display("FAIL mul_lt got=%b exp=1", bus32.isLessThan); end

        drive32(5'b00110, 32'h00010000, 32'h00010000, 5'd0);
        wait_done32(lat, busy);
        total++; if (bus32.data_result !== 32'h0) begin bad++; $display("FAIL mul_big_result got=%h exp=0", bus32.data_result); end
        total++; if (bus32.overflow !== 1'b1) begin bad++; $display("FAIL mul_big_overflow got=%b exp=1", bus32.overflow); end
        total++; if (bus32.isNotEqual !== 1'b0) begin bad++; $display("FAIL mul_big_ne got=%b exp=0", bus32.isNotEqual); end
    endtask

    task automatic test_div;
        int lat, busy;
        drive32(5'b00111, 32'hFFFFFFF9, 32'd2, 5'd0);
        wait_done32(lat, busy);
        total++; if (lat != 32) begin bad++; $display("FAIL div_latency got=%0d exp=32", lat); end
        total++; if (bus32.data_result !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_result got=%h exp=fffffffd", bus32.data_result); end
        total++; if (bus32.overflow !== 1'b0) begin bad++; $display("FAIL div_overflow got=%b exp=0", bus32.overflow); end

        drive32(5'b00111, 32'd9, 32'd0, 5'd0);
        wait_done32(lat, busy);
        total++; if (lat != 32) begin bad++; $display("FAIL div0_latency got=%0d exp=32", lat); end
        total++; if (bus32.data_result !== 32'h0) begin bad++; $display("FAIL div0_result got=%h exp=0", bus32.data_result); end
        total++; if (bus32.data_exception !== 1'b1) begin bad++; $display("FAIL div0_exc got=%b exp=1", bus32.data_exception); end
        total++; if (bus32.overflow !== 1'b0) begin bad++; $display("FAIL div0_overflow got=%b exp=0", bus32.overflow); end
        repeat (3) @(negedge clk);
        total++; if (bus32.out_valid !== 1'b0) begin bad++; $display("FAIL div0_hold_valid got=%b exp=0", bus32.out_valid); end
        total++; if (bus32.data_exception !== 1'b1) begin bad++; $display("FAIL div0_hold_exc got=%b exp=1", bus32.data_exception); end

        drive32(5'b00111, 32'h80000000, 32'hFFFFFFFF, 5'd0);
        wait_done32(lat, busy);
        total++; if (bus32.data_result !== 32'h80000000) begin bad++; $display("FAIL divmin_result got=%h exp=80000000", bus32.data_result); end
        total++; if (bus32.overflow !== 1'b1) begin bad++; $display("FAIL divmin_overflow got=%b exp=1", bus32.overflow); end
        total++; if (bus32.data_exception !== 1'b0) begin bad++; $display("FAIL divmin_exc got=%b exp=0", bus32.data_exception); end
        total++; if (bus32.isLessThan !== 1'b1) begin bad++; $display("FAIL divmin_lt got=%b exp=1", bus32.isLessThan); end
    endtask

    task automatic test_reset_mid_div;
        int lat, busy, seen;
        drive32(5'b00000, 32'h7FFFFFFF, 32'h1, 5'd0);
        wait_done32(lat, busy);
        drive32(5'b00111, 32'd100, 32'd7, 5'd0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (bus32.data_result !== 32'h0) begin bad++; $display("FAIL rstmid_result got=%h exp=0", bus32.data_result); end
        total++; if (bus32.overflow !== 1'b0) begin bad++; $display("FAIL rstmid_overflow got=%b exp=0", bus32.overflow); end
        total++; if (bus32.isNotEqual !== 1'b0) begin bad++; $display("FAIL rstmid_ne got=%b exp=0", bus32.isNotEqual); end
        total++; if (dbg_state32 !== 2'd0) begin bad++; $display("FAIL rstmid_state got=%0d exp=0", dbg_state32); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (bus32.in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", bus32.in_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus32.out_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_valid got=%0d exp=0", seen); end
    endtask

    task automatic test_width8;
        int lat;
        @(negedge clk);
        bus8.ctrl_ALUopcode = 5'b00110;
        bus8.data_operandA  = 8'd12;
        bus8.data_operandB  = 8'd11;
        bus8.ctrl_shiftamt  = 3'd0;
        bus8.in_valid       = 1'b1;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus8.out_valid) break;
            @(posedge clk);
            lat++;
        end
        total++; if (lat != 8) begin bad++; $display("FAIL w8_latency got=%0d exp=8", lat); end
        total++; if (bus8.data_result !== 8'h84) begin bad++; $display("FAIL w8_result got=%h exp=84", bus8.data_result); end
        total++; if (bus8.overflow !== 1'b1) begin bad++; $display("FAIL w8_overflow got=%b exp=1", bus8.overflow); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus32.in_valid = 1'b0; bus32.data_operandA = '0; bus32.data_operandB = '0;
        bus32.ctrl_ALUopcode = '0; bus32.ctrl_shiftamt = '0;
        bus8.in_valid = 1'b0; bus8.data_operandA = '0; bus8.data_operandB = '0;
        bus8.ctrl_ALUopcode = '0; bus8.ctrl_shiftamt = '0;
        test_reset;
        test_single;
        test_back_to_back;
        test_mul;
        test_div;
        test_reset_mid_div;
        test_width8;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_iterative.md
Name: alu_iterative

Overview:
- Parametrised, handshaked successor to the processor's combinational ALU.
- Single-cycle ops: add, sub, and, or, sll, sra. Iterative signed multiply and divide: one bit per cycle.
- Sits between decode/regfile read and writeback. The pipeline stalls on in_ready low.
- All outputs are registered and hold until the next completion.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥4 and a power of two.
- SHW, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request this cycle
- data_operandA  input  WIDTH  operand A (signed)
- data_operandB  input  WIDTH  operand B (signed)
- ctrl_ALUopcode  input  5  operation select
- ctrl_shiftamt  input  SHW  shift distance
- out_valid  output  1  one-cycle pulse: result/flags updated
- data_result  output  WIDTH  result
- isNotEqual  output  1  A != B
- isLessThan  output  1  A < B, signed
- overflow  output  1  signed overflow of the op
- data_exception  output  1  divide by zero

Behaviour:
- Opcodes:
  - 00000 add; 00001 sub; 00010 and; 00011 or.
  - 00100 sll; 00101 sra; 00110 mul; 00111 div.
  - Any other opcode: result 0, overflow 0, exception 0, handled as a single-cycle op.
- Accept on a rising edge with in_valid && in_ready. Operands, opcode and shiftamt are captured there; input changes afterwards are ignored.
- FSM states IDLE, BUSY, DONE. Reset state is IDLE.
  - in_ready = (state != BUSY), decoded from state.
  - IDLE/DONE, accept single-cycle op -> DONE. Result computed and registered at the accept edge. out_valid high the following cycle. Gives back-to-back throughput of 1/cycle.
  - IDLE/DONE, accept mul/div -> BUSY. An iteration counter loads WIDTH-1 and decrements each edge. On the edge where the count is 0: register the result, go to DONE. out_valid is therefore high in cycle WIDTH after the accept edge.
  - DONE with no accept -> IDLE. out_valid is 1 only in DONE.
- isNotEqual and isLessThan are computed from A-B for every op and registered with the result.
  - isLessThan = sign(A-B) XOR sub-overflow, so it is correct at the extremes.
- add/sub overflow: operand signs agree (after B inversion for sub) and the result sign differs.
- Shifts: sll is logical left by shiftamt; sra is arithmetic right by shiftamt. overflow is 0 for shifts and logic ops.
- mul: signed; result is the low WIDTH bits. overflow = 1 when the full 2*WIDTH product is not the sign-extension of the low WIDTH bits. Implementation: shift-add on magnitudes, then sign fix-up.
- div: signed restoring division on magnitudes; quotient truncates toward zero.
  - B == 0: result 0, data_exception 1, overflow 0, same latency.
  - A == most-negative and B == -1: result = most-negative, overflow 1.
- data_exception is cleared on every completion that is not a divide by zero.
- Reset, asynchronous: state IDLE; counter 0; data_result 0; all flags 0; out_valid 0. in_ready is 1 as soon as reset deasserts.
- Reset asserted mid-BUSY aborts the operation. No out_valid is produced for it.
- in_valid while BUSY is ignored. The requester must hold it until in_ready.

Test Plan:
- WIDTH=32, add 0x7FFFFFFF + 1 -> out_valid the next cycle; result 0x80000000; overflow 1; isLessThan 0; isNotEqual 1.
- Back-to-back sub 5-5, then sub -3-2, on consecutive cycles -> two consecutive out_valid pulses.
  - First: result 0, isNotEqual 0.
  - Second: result 0xFFFFFFFB, isLessThan 1.
  - in_ready stays 1 throughout.
- mul -7 * 6 -> in_ready low for 32 cycles; out_valid exactly 32 cycles after accept; result 0xFFFFFFD6; overflow 0.
- mul 0x00010000 * 0x00010000 -> result 0 with overflow 1.
- div -7 / 2 -> result 0xFFFFFFFD.
- div 9 / 0 -> result 0, data_exception 1.
- div 0x80000000 / -1 -> result 0x80000000, overflow 1.
- sra 0x80000000 by 31 -> 0xFFFFFFFF.
- Reset asserted 10 cycles into a div -> outputs 0 immediately; no out_valid; in_ready 1 after reset release.
- WIDTH=8 (SHW=3): mul 12 * 11 -> result 0x84, overflow 1, out_valid 8 cycles after accept.
